// File: rtl/branch_pkg.sv
// Shared types for the branch reservation station: op encodings, entry layout,
// issue-bundle width and the function that packs an entry into the issue bundle.
package branch_pkg;

    localparam int BRS_BUNDLE_W  = 106;
    // Tags are stored zero-extended to this width so the entry struct does not
    // depend on the station's TAG_W parameter.
    localparam int BRS_TAG_MAX_W = 16;

    // [4:3] class, [2:0] funct3
    typedef enum logic [4:0] {
        BR_BEQ  = 5'b00_000,
        BR_BNE  = 5'b00_001,
        BR_BLT  = 5'b00_100,
        BR_BGE  = 5'b00_101,
        BR_BLTU = 5'b00_110,
        BR_BGEU = 5'b00_111,
        BR_JAL  = 5'b01_000,
        BR_JALR = 5'b10_000
    } branch_op_e;

    typedef struct packed {
        logic                     rdy;
        logic [BRS_TAG_MAX_W-1:0] tag;
        logic [31:0]              val;
    } brs_src_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] imm;
        brs_src_t    src1;
        brs_src_t    src2;
    } brs_entry_t;

    // Issue bundle: {op, rd, src1, src2, imm}
    function automatic logic [BRS_BUNDLE_W-1:0] brs_pack(input brs_entry_t e);
        return {e.op, e.rd, e.src1.val, e.src2.val, e.imm};
    endfunction

endpackage

// File: rtl/branch_rs_pick.sv
// Lowest-index priority encoder. Used for free-slot and ready-entry selection.
module branch_rs_pick #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]         req,
    output logic                     found,
    output logic [$clog2(DEPTH)-1:0] idx
);

    localparam int IDX_W = $clog2(DEPTH);

    // Scan from the top down so the lowest requesting index is the last one written.
    always_comb begin
        found = |req;
        idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/branch_rs.sv
// Branch reservation station. Holds dispatched branch ops until both operands are
// captured (at dispatch or from the CDB), then issues one op at a time to the
// branch unit. Optional feature macro: BRS_FLUSH_EN adds a flush input that
// empties the station and clears the busy state.
module branch_rs
    import branch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    disp_valid,
    output logic                    disp_ready,
    input  logic [4:0]              disp_op,
    input  logic [4:0]              disp_rd,
    input  logic [31:0]             disp_pc,
    input  logic [31:0]             disp_imm,
    input  logic                    disp_src1_rdy,
    input  logic [TAG_W-1:0]        disp_src1_tag,
    input  logic [31:0]             disp_src1_val,
    input  logic                    disp_src2_rdy,
    input  logic [TAG_W-1:0]        disp_src2_tag,
    input  logic [31:0]             disp_src2_val,
    input  logic                    cdb_valid,
    input  logic [TAG_W-1:0]        cdb_tag,
    input  logic [31:0]             cdb_val,
    input  logic                    exec_finish,
    output logic                    issue_start,
    output logic [BRS_BUNDLE_W-1:0] issue_rs,
    output logic [31:0]             issue_pc
`ifdef BRS_FLUSH_EN
    ,
    input  logic                    flush
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    logic flush_int;
`ifdef BRS_FLUSH_EN
    assign flush_int = flush;
`else
    assign flush_int = 1'b0;
`endif

    brs_entry_t               entry_q [DEPTH];
    brs_entry_t               disp_entry;
    logic [DEPTH-1:0]         free_vec;
    logic [DEPTH-1:0]         ready_vec;
    logic                     free_found;
    logic [IDX_W-1:0]         free_idx;
    logic                     ready_found;
    logic [IDX_W-1:0]         sel_idx;
    logic                     sel_fire;
    logic                     disp_fire;
    logic [BRS_TAG_MAX_W-1:0] cdb_tag_ext;

    logic                     issue_start_reg;
    logic [BRS_BUNDLE_W-1:0]  issue_rs_reg;
    logic [31:0]              issue_pc_reg;
    logic                     busy_reg;

    assign cdb_tag_ext = BRS_TAG_MAX_W'(cdb_tag);

    // disp_ready looks only at registered occupancy; a slot freed by this cycle's
    // issue becomes available next cycle.
    assign disp_ready = free_found;
    assign disp_fire  = disp_valid && free_found && !flush_int;
    // A finishing op frees the unit in time for this cycle's selection.
    assign sel_fire   = ready_found && (!busy_reg || exec_finish);

    branch_rs_pick #(.DEPTH(DEPTH)) u_free_pick (
        .req   (free_vec),
        .found (free_found),
        .idx   (free_idx)
    );

    branch_rs_pick #(.DEPTH(DEPTH)) u_ready_pick (
        .req   (ready_vec),
        .found (ready_found),
        .idx   (sel_idx)
    );

    // New entry, with same-cycle CDB bypass for operands not ready at dispatch
    always_comb begin
        disp_entry          = '0;
        disp_entry.valid    = 1'b1;
        disp_entry.op       = disp_op;
        disp_entry.rd       = disp_rd;
        disp_entry.pc       = disp_pc;
        disp_entry.imm      = disp_imm;
        disp_entry.src1.tag = BRS_TAG_MAX_W'(disp_src1_tag);
        disp_entry.src1.rdy = disp_src1_rdy || (cdb_valid && (disp_src1_tag == cdb_tag));
        disp_entry.src1.val = disp_src1_rdy ? disp_src1_val : cdb_val;
        disp_entry.src2.tag = BRS_TAG_MAX_W'(disp_src2_tag);
        disp_entry.src2.rdy = disp_src2_rdy || (cdb_valid && (disp_src2_tag == cdb_tag));
        disp_entry.src2.val = disp_src2_rdy ? disp_src2_val : cdb_val;
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        brs_entry_t entry_reg;
        brs_entry_t entry_next;

        assign entry_q[gi]   = entry_reg;
        assign free_vec[gi]  = !entry_reg.valid;
        assign ready_vec[gi] = entry_reg.valid && entry_reg.src1.rdy && entry_reg.src2.rdy;

        // Wakeup from CDB, release on issue, overwrite on dispatch into a free slot
        always_comb begin
            entry_next = entry_reg;
            if (cdb_valid && entry_reg.valid && !entry_reg.src1.rdy &&
                (entry_reg.src1.tag == cdb_tag_ext)) begin
                entry_next.src1.rdy = 1'b1;
                entry_next.src1.val = cdb_val;
            end
            if (cdb_valid && entry_reg.valid && !entry_reg.src2.rdy &&
                (entry_reg.src2.tag == cdb_tag_ext)) begin
                entry_next.src2.rdy = 1'b1;
                entry_next.src2.val = cdb_val;
            end
            if (sel_fire && (sel_idx == IDX_W'(gi))) begin
                entry_next.valid = 1'b0;
            end
            if (disp_fire && (free_idx == IDX_W'(gi))) begin
                entry_next = disp_entry;
            end
        end

        // Entry storage; reset and flush empty the slot
        always_ff @(posedge clk) begin
            if (reset || flush_int) begin
                entry_reg <= '0;
            end else begin
                entry_reg <= entry_next;
            end
        end
    end

    // Registered issue outputs and branch-unit busy tracking
    always_ff @(posedge clk) begin
        if (reset || flush_int) begin
            issue_start_reg <= 1'b0;
            issue_rs_reg    <= '0;
            issue_pc_reg    <= '0;
            busy_reg        <= 1'b0;
        end else begin
            issue_start_reg <= sel_fire;
            if (sel_fire) begin
                issue_rs_reg <= brs_pack(entry_q[sel_idx]);
                issue_pc_reg <= entry_q[sel_idx].pc;
                busy_reg     <= 1'b1;
            end else if (exec_finish) begin
                busy_reg     <= 1'b0;
            end
        end
    end

    assign issue_start = issue_start_reg;
    assign issue_rs    = issue_rs_reg;
    assign issue_pc    = issue_pc_reg;

endmodule

// File: tb/tb_branch_rs.sv
// Directed bench for branch_rs. Stimulus pushes expected issues (bundle, pc and
// the cycle on which issue_start must appear) into a queue; a negedge monitor
// pops and compares every issue the DUT presents.
module tb_branch_rs;

    logic         clk = 1'b0;
    logic         reset;
    logic         disp_valid;
    logic         disp_ready;
    logic [4:0]   disp_op;
    logic [4:0]   disp_rd;
    logic [31:0]  disp_pc;
    logic [31:0]  disp_imm;
    logic         disp_src1_rdy;
    logic [3:0]   disp_src1_tag;
    logic [31:0]  disp_src1_val;
    logic         disp_src2_rdy;
    logic [3:0]   disp_src2_tag;
    logic [31:0]  disp_src2_val;
    logic         cdb_valid;
    logic [3:0]   cdb_tag;
    logic [31:0]  cdb_val;
    logic         exec_finish;
    logic         issue_start;
    logic [105:0] issue_rs;
    logic [31:0]  issue_pc;
`ifdef BRS_FLUSH_EN
    logic         flush;
`endif

    typedef struct {
        logic [105:0] rs;
        logic [31:0]  pc;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    branch_rs #(.DEPTH(4), .TAG_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .disp_op       (disp_op),
        .disp_rd       (disp_rd),
        .disp_pc       (disp_pc),
        .disp_imm      (disp_imm),
        .disp_src1_rdy (disp_src1_rdy),
        .disp_src1_tag (disp_src1_tag),
        .disp_src1_val (disp_src1_val),
        .disp_src2_rdy (disp_src2_rdy),
        .disp_src2_tag (disp_src2_tag),
        .disp_src2_val (disp_src2_val),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_val       (cdb_val),
        .exec_finish   (exec_finish),
        .issue_start   (issue_start),
        .issue_rs      (issue_rs),
        .issue_pc      (issue_pc)
`ifdef BRS_FLUSH_EN
        ,
        .flush         (flush)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every issue_start must match the oldest queued expectation
    always @(negedge clk) begin
        if (issue_start === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_issue: got issue rs=%0h pc=%0h at cycle %0d, expected no issue",
                         issue_rs, issue_pc, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                $display("[TB] issue cycle=%0d pc=%0h rs=%0h", cyc, issue_pc, issue_rs);
                check("issue_rs", 128'(issue_rs), 128'(mon_e.rs));
                check("issue_pc", 128'(issue_pc), 128'(mon_e.pc));
                check("issue_cycle", 128'(cyc), 128'(mon_e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        disp_valid  = 1'b0;
        cdb_valid   = 1'b0;
        exec_finish = 1'b0;
    endtask

    task automatic set_disp(input logic [4:0] op, input logic [4:0] rd,
                            input logic [31:0] pc, input logic [31:0] imm,
                            input logic r1, input logic [3:0] t1, input logic [31:0] v1,
                            input logic r2, input logic [3:0] t2, input logic [31:0] v2);
        disp_valid    = 1'b1;
        disp_op       = op;
        disp_rd       = rd;
        disp_pc       = pc;
        disp_imm      = imm;
        disp_src1_rdy = r1;
        disp_src1_tag = t1;
        disp_src1_val = v1;
        disp_src2_rdy = r2;
        disp_src2_tag = t2;
        disp_src2_val = v2;
    endtask

    task automatic set_cdb(input logic [3:0] tag, input logic [31:0] val);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_val   = val;
    endtask

    task automatic push(input logic [105:0] rs, input logic [31:0] pc, input int c);
        exp_t e;
        e.rs  = rs;
        e.pc  = pc;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic finish_pulse();
        exec_finish = 1'b1;
        tick();
        exec_finish = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_issue_start"}, 128'(issue_start), 128'(0));
        check({tag, "_issue_rs"},    128'(issue_rs),    128'(0));
        check({tag, "_issue_pc"},    128'(issue_pc),    128'(0));
        check({tag, "_disp_ready"},  128'(disp_ready),  128'(1));
    endtask

    initial begin
        reset = 1'b1;
        clear_in();
        set_disp(5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        disp_valid = 1'b0;
        cdb_tag    = 4'd0;
        cdb_val    = 32'd0;
`ifdef BRS_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (3) tick();
        reset = 1'b0;
        check_idle("reset");

        // 1: both operands ready at dispatch
        set_disp(5'b00000, 5'd1, 32'h100, 32'h20, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd5);
        push({5'b00000, 5'd1, 32'd5, 32'd5, 32'h20}, 32'h100, cyc + 2);
        tick(); clear_in();
        tick();
        finish_pulse();

        // 2: src1 waits for tag 3, broadcast two cycles after dispatch
        set_disp(5'b00001, 5'd2, 32'h200, 32'h40, 1'b0, 4'd3, 32'd0, 1'b1, 4'd0, 32'h9);
        tick(); clear_in();
        tick();
        set_cdb(4'd3, 32'h7);
        push({5'b00001, 5'd2, 32'h7, 32'h9, 32'h40}, 32'h200, cyc + 2);
        tick(); clear_in();
        tick();
        finish_pulse();

        // 3: dispatch-cycle bypass on src2
        set_disp(5'b00100, 5'd3, 32'h300, 32'hFFFF_FFF0, 1'b1, 4'd0, 32'h1, 1'b0, 4'd9, 32'd0);
        set_cdb(4'd9, 32'hAB);
        push({5'b00100, 5'd3, 32'h1, 32'hAB, 32'hFFFF_FFF0}, 32'h300, cyc + 2);
        tick(); clear_in();
        tick();
        finish_pulse();

        // 4: fill all entries with unready ops, overflow dispatch is dropped
        for (int i = 0; i < 4; i++) begin
            set_disp(5'b00101, 5'(4 + i), 32'h400 + 32'(4 * i), 32'(i),
                     1'b0, 4'(i + 1), 32'd0, 1'b1, 4'd0, 32'h10 + 32'(i));
            tick();
        end
        clear_in();
        check("full_disp_ready", 128'(disp_ready), 128'(0));
        set_disp(5'b00000, 5'd9, 32'h500, 32'h0, 1'b1, 4'd0, 32'h1, 1'b1, 4'd0, 32'h1);
        tick(); clear_in();
        check("full_after_drop", 128'(disp_ready), 128'(0));
        tick();
        set_cdb(4'd3, 32'h33);
        push({5'b00101, 5'd6, 32'h33, 32'h12, 32'd2}, 32'h408, cyc + 2);
        tick(); clear_in();
        check("ready_before_free", 128'(disp_ready), 128'(0));
        tick();
        check("ready_after_free", 128'(disp_ready), 128'(1));

        // 6: reset with three entries held and busy set; concurrent dispatch and CDB ignored
        reset = 1'b1;
        set_disp(5'b00000, 5'd12, 32'h700, 32'h0, 1'b1, 4'd0, 32'h1, 1'b1, 4'd0, 32'h1);
        set_cdb(4'd1, 32'h55);
        tick();
        reset = 1'b0;
        clear_in();
        check_idle("midreset");
        set_cdb(4'd1, 32'h1); tick();
        set_cdb(4'd2, 32'h2); tick();
        set_cdb(4'd4, 32'h4); tick();
        clear_in();
        repeat (2) tick();

`ifdef BRS_FLUSH_EN
        // Flush with an op in flight and two waiting entries; concurrent dispatch dropped
        set_disp(5'b00000, 5'd13, 32'h800, 32'h4, 1'b1, 4'd0, 32'h2, 1'b1, 4'd0, 32'h3);
        push({5'b00000, 5'd13, 32'h2, 32'h3, 32'h4}, 32'h800, cyc + 2);
        tick();
        set_disp(5'b00001, 5'd14, 32'h804, 32'h0, 1'b0, 4'd5, 32'd0, 1'b1, 4'd0, 32'h0);
        tick();
        set_disp(5'b00001, 5'd15, 32'h808, 32'h0, 1'b0, 4'd6, 32'd0, 1'b1, 4'd0, 32'h0);
        tick();
        flush = 1'b1;
        set_disp(5'b00000, 5'd16, 32'h80C, 32'h0, 1'b1, 4'd0, 32'h1, 1'b1, 4'd0, 32'h1);
        tick();
        flush = 1'b0;
        clear_in();
        check_idle("flush");
        set_cdb(4'd5, 32'h5); tick();
        set_cdb(4'd6, 32'h6); tick();
        clear_in();
        repeat (2) tick();
`endif

        // 5: two ready entries, unit held busy for three cycles
        set_disp(5'b00110, 5'd10, 32'h600, 32'h8, 1'b1, 4'd0, 32'h1, 1'b1, 4'd0, 32'h2);
        push({5'b00110, 5'd10, 32'h1, 32'h2, 32'h8}, 32'h600, cyc + 2);
        tick();
        set_disp(5'b00111, 5'd11, 32'h604, 32'hC, 1'b1, 4'd0, 32'h3, 1'b1, 4'd0, 32'h4);
        tick(); clear_in();
        repeat (3) tick();
        push({5'b00111, 5'd11, 32'h3, 32'h4, 32'hC}, 32'h604, cyc + 1);
        finish_pulse();
        tick();
        finish_pulse();
        repeat (4) tick();

        check("pending_issues", 128'(exp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
